// File: rtl/dma_cpu_mem_arbiter_pkg.sv
// rtl/dma_cpu_mem_arbiter_pkg.sv - shared types and widths for the CPU/DMA bus arbiter
package dma_cpu_mem_arbiter_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CPU = 2'd1,
    GRANT_DMA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dma_burst_limiter.sv
// rtl/dma_burst_limiter.sv - saturating DMA burst counter that forces a CPU grant
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   dma_grant    IDLE -> GRANT_DMA transition this cycle
//   cpu_grant    IDLE -> GRANT_CPU transition this cycle
//   idle_entry   GRANT_x -> IDLE transition this cycle
//   cpu_pending  CPU request level
//   force_cpu    counter has reached MAX_DMA_BURST; CPU must win next arbitration
module dma_burst_limiter
  import dma_cpu_mem_arbiter_pkg::*;
#(
  parameter int MAX_DMA_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_grant,
  input  logic cpu_grant,
  input  logic idle_entry,
  input  logic cpu_pending,
  output logic force_cpu
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DMA_BURST);

  logic [CNT_W-1:0] cnt;

  // Only DMA grants that overtook a waiting CPU count against the budget;
  // the budget resets once the CPU is served or has stopped asking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cpu_grant || (idle_entry && !cpu_pending)) begin
      cnt <= '0;
    end else if (dma_grant && cpu_pending && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_cpu = (cnt == MAX_CNT);

endmodule

// File: rtl/dma_cpu_mem_arbiter.sv
// rtl/dma_cpu_mem_arbiter.sv - two-master (CPU, DMA) arbiter for the shared memory/IO bus
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cpu_m_*, cpu_d_io   CPU data port request side; cpu_m_ack/cpu_m_data_in back to CPU
//   dma_m_*, dma_d_io   DMA request side; dma_m_ack/dma_m_data_in back to DMA
//   q_m_*, q_d_io       shared bus towards RAM and IO decode
//   dma_active          DMA currently owns the bus
module dma_cpu_mem_arbiter
  import dma_cpu_mem_arbiter_pkg::*;
#(
  parameter int MAX_DMA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] cpu_m_addr,
  input  logic [DATA_W-1:0] cpu_m_data_out,
  output logic [DATA_W-1:0] cpu_m_data_in,
  input  logic              cpu_m_access,
  output logic              cpu_m_ack,
  input  logic              cpu_m_wr_en,
  input  logic [1:0]        cpu_m_bytesel,
  input  logic              cpu_d_io,

  input  logic [ADDR_W-1:0] dma_m_addr,
  input  logic [DATA_W-1:0] dma_m_data_out,
  output logic [DATA_W-1:0] dma_m_data_in,
  input  logic              dma_m_access,
  output logic              dma_m_ack,
  input  logic              dma_m_wr_en,
  input  logic [1:0]        dma_m_bytesel,
  input  logic              dma_d_io,

  output logic [ADDR_W-1:0] q_m_addr,
  output logic [DATA_W-1:0] q_m_data_out,
  input  logic [DATA_W-1:0] q_m_data_in,
  output logic              q_m_access,
  input  logic              q_m_ack,
  output logic              q_m_wr_en,
  output logic [1:0]        q_m_bytesel,
  output logic              q_d_io,

  output logic              dma_active
);

  arb_state_e state;
  arb_state_e state_next;

  logic dma_grant;
  logic cpu_grant;
  logic idle_entry;
  logic force_cpu;

  dma_burst_limiter #(
    .MAX_DMA_BURST(MAX_DMA_BURST)
  ) u_limiter (
    .clk        (clk),
    .reset      (reset),
    .dma_grant  (dma_grant),
    .cpu_grant  (cpu_grant),
    .idle_entry (idle_entry),
    .cpu_pending(cpu_m_access),
    .force_cpu  (force_cpu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests only steer the next state; the bus itself is driven from the
  // registered state, so access never reaches q_m_access combinationally.
  always_comb begin
    state_next = state;
    dma_grant  = 1'b0;
    cpu_grant  = 1'b0;
    idle_entry = 1'b0;
    case (state)
      IDLE: begin
        if (dma_m_access && !(cpu_m_access && force_cpu)) begin
          state_next = GRANT_DMA;
          dma_grant  = 1'b1;
        end else if (cpu_m_access) begin
          state_next = GRANT_CPU;
          cpu_grant  = 1'b1;
        end
      end
      GRANT_CPU, GRANT_DMA: begin
        // Grant is held until the slave answers, even if the master lets go.
        if (q_m_ack) begin
          state_next = IDLE;
          idle_entry = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_d_io       = 1'b0;
    dma_active   = 1'b0;
    cpu_m_ack    = 1'b0;
    dma_m_ack    = 1'b0;
    case (state)
      GRANT_CPU: begin
        q_m_addr     = cpu_m_addr;
        q_m_data_out = cpu_m_data_out;
        q_m_access   = 1'b1;
        q_m_wr_en    = cpu_m_wr_en;
        q_m_bytesel  = cpu_m_bytesel;
        q_d_io       = cpu_d_io;
        cpu_m_ack    = q_m_ack;
      end
      GRANT_DMA: begin
        q_m_addr     = dma_m_addr;
        q_m_data_out = dma_m_data_out;
        q_m_access   = 1'b1;
        q_m_wr_en    = dma_m_wr_en;
        q_m_bytesel  = dma_m_bytesel;
        q_d_io       = dma_d_io;
        dma_active   = 1'b1;
        dma_m_ack    = q_m_ack;
      end
      default: begin
      end
    endcase
  end

  // Read data fans out to both masters; only the ack makes it meaningful.
  assign cpu_m_data_in = q_m_data_in;
  assign dma_m_data_in = q_m_data_in;

endmodule

// File: tb/tb_dma_cpu_mem_arbiter.sv
// tb/tb_dma_cpu_mem_arbiter.sv - directed self-checking bench for dma_cpu_mem_arbiter
module tb_dma_cpu_mem_arbiter;
  import dma_cpu_mem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_m_addr;
  logic [DATA_W-1:0] cpu_m_data_out;
  logic [DATA_W-1:0] cpu_m_data_in;
  logic              cpu_m_access;
  logic              cpu_m_ack;
  logic              cpu_m_wr_en;
  logic [1:0]        cpu_m_bytesel;
  logic              cpu_d_io;
  logic [ADDR_W-1:0] dma_m_addr;
  logic [DATA_W-1:0] dma_m_data_out;
  logic [DATA_W-1:0] dma_m_data_in;
  logic              dma_m_access;
  logic              dma_m_ack;
  logic              dma_m_wr_en;
  logic [1:0]        dma_m_bytesel;
  logic              dma_d_io;
  logic [ADDR_W-1:0] q_m_addr;
  logic [DATA_W-1:0] q_m_data_out;
  logic [DATA_W-1:0] q_m_data_in;
  logic              q_m_access;
  logic              q_m_ack;
  logic              q_m_wr_en;
  logic [1:0]        q_m_bytesel;
  logic              q_d_io;
  logic              dma_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_cpu_mem_arbiter #(.MAX_DMA_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_m_addr(cpu_m_addr), .cpu_m_data_out(cpu_m_data_out), .cpu_m_data_in(cpu_m_data_in),
    .cpu_m_access(cpu_m_access), .cpu_m_ack(cpu_m_ack), .cpu_m_wr_en(cpu_m_wr_en),
    .cpu_m_bytesel(cpu_m_bytesel), .cpu_d_io(cpu_d_io),
    .dma_m_addr(dma_m_addr), .dma_m_data_out(dma_m_data_out), .dma_m_data_in(dma_m_data_in),
    .dma_m_access(dma_m_access), .dma_m_ack(dma_m_ack), .dma_m_wr_en(dma_m_wr_en),
    .dma_m_bytesel(dma_m_bytesel), .dma_d_io(dma_d_io),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_d_io(q_d_io), .dma_active(dma_active)
  );

  task automatic test_reset;
    reset = 1'b1;
    cpu_m_addr = '0; cpu_m_data_out = '0; cpu_m_access = 1'b0; cpu_m_wr_en = 1'b0;
    cpu_m_bytesel = 2'b00; cpu_d_io = 1'b0;
    dma_m_addr = '0; dma_m_data_out = '0; dma_m_access = 1'b0; dma_m_wr_en = 1'b0;
    dma_m_bytesel = 2'b00; dma_d_io = 1'b0;
    q_m_data_in = '0; q_m_ack = 1'b0;
    #12;
    checks++; if (q_m_access !== 1'b0) begin errors++; $display("FAIL reset_q_m_access got %b exp 0", q_m_access); end
    checks++; if (q_m_addr !== 19'h0) begin errors++; $display("FAIL reset_q_m_addr got %h exp 0", q_m_addr); end
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_dma_active got %b exp 0", dma_active); end
    checks++; if ({cpu_m_ack, dma_m_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {cpu_m_ack, dma_m_ack}); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state); end
    checks++; if (dut.u_limiter.cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.u_limiter.cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_cpu_read;
    @(posedge clk); #1;
    cpu_m_addr = 19'h12345; cpu_m_access = 1'b1; cpu_m_wr_en = 1'b0; cpu_m_bytesel = 2'b11;
    #1;
    checks++; if (q_m_access !== 1'b0) begin errors++; $display("FAIL cpu_read_no_comb_grant got %b exp 0", q_m_access); end
    @(posedge clk); #1;
    checks++; if (q_m_access !== 1'b1) begin errors++; $display("FAIL cpu_read_grant_latency got %b exp 1", q_m_access); end
    checks++; if (q_m_addr !== 19'h12345) begin errors++; $display("FAIL cpu_read_addr got %h exp 12345", q_m_addr); end
    @(posedge clk); #1;
    checks++; if (cpu_m_ack !== 1'b0) begin errors++; $display("FAIL cpu_read_early_ack got %b exp 0", cpu_m_ack); end
    @(posedge clk); #1;
    q_m_ack = 1'b1; q_m_data_in = 16'hBEEF;
    #1;
    checks++; if (cpu_m_ack !== 1'b1) begin errors++; $display("FAIL cpu_read_ack got %b exp 1", cpu_m_ack); end
    checks++; if (cpu_m_data_in !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data got %h exp BEEF", cpu_m_data_in); end
    checks++; if (dma_m_ack !== 1'b0) begin errors++; $display("FAIL cpu_read_dma_ack got %b exp 0", dma_m_ack); end
    @(posedge clk); #1;
    q_m_ack = 1'b0; cpu_m_access = 1'b0;
    #1;
    checks++; if ({q_m_access, cpu_m_ack} !== 2'b00) begin errors++; $display("FAIL cpu_read_ack_single got %b exp 00", {q_m_access, cpu_m_ack}); end
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    cpu_m_addr = 19'h0AAAA; cpu_d_io = 1'b0; cpu_m_access = 1'b1;
    dma_m_addr = 19'h55555; dma_d_io = 1'b1; dma_m_access = 1'b1;
    @(posedge clk); #1;
    checks++; if (dma_active !== 1'b1) begin errors++; $display("FAIL simul_dma_first got %b exp 1", dma_active); end
    checks++; if (q_m_addr !== 19'h55555) begin errors++; $display("FAIL simul_dma_addr got %h exp 55555", q_m_addr); end
    checks++; if (q_d_io !== 1'b1) begin errors++; $display("FAIL simul_dma_io got %b exp 1", q_d_io); end
    q_m_ack = 1'b1;
    #1;
    checks++; if ({dma_m_ack, cpu_m_ack} !== 2'b10) begin errors++; $display("FAIL simul_dma_ack got %b exp 10", {dma_m_ack, cpu_m_ack}); end
    @(posedge clk); #1;
    q_m_ack = 1'b0; dma_m_access = 1'b0; dma_d_io = 1'b0;
    #1;
    checks++; if (q_m_access !== 1'b0) begin errors++; $display("FAIL simul_idle_gap got %b exp 0", q_m_access); end
    checks++; if (dut.u_limiter.cnt !== 4'd1) begin errors++; $display("FAIL simul_cnt_after_dma got %0d exp 1", dut.u_limiter.cnt); end
    @(posedge clk); #1;
    checks++; if ({q_m_access, dma_active} !== 2'b10) begin errors++; $display("FAIL simul_cpu_grant got %b exp 10", {q_m_access, dma_active}); end
    checks++; if (q_m_addr !== 19'h0AAAA) begin errors++; $display("FAIL simul_cpu_addr got %h exp 0AAAA", q_m_addr); end
    checks++; if (dut.u_limiter.cnt !== 4'd0) begin errors++; $display("FAIL simul_cnt_cleared got %0d exp 0", dut.u_limiter.cnt); end
    q_m_ack = 1'b1;
    #1;
    checks++; if ({cpu_m_ack, dma_m_ack} !== 2'b10) begin errors++; $display("FAIL simul_cpu_ack got %b exp 10", {cpu_m_ack, dma_m_ack}); end
    @(posedge clk); #1;
    q_m_ack = 1'b0; cpu_m_access = 1'b0;
  endtask

  task automatic test_burst_limit;
    logic exp_dma;
    @(posedge clk); #1;
    cpu_m_addr = 19'h01111; dma_m_addr = 19'h02222;
    cpu_m_access = 1'b1; dma_m_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_dma = (i != 4);
      @(posedge clk); #1;
      checks++; if ({q_m_access, dma_active} !== {1'b1, exp_dma}) begin errors++; $display("FAIL burst_grant_%0d got %b exp %b", i, {q_m_access, dma_active}, {1'b1, exp_dma}); end
      checks++; if (q_m_addr !== (exp_dma ? 19'h02222 : 19'h01111)) begin errors++; $display("FAIL burst_addr_%0d got %h", i, q_m_addr); end
      if (i == 3) begin
        checks++; if (dut.u_limiter.cnt !== 4'd4) begin errors++; $display("FAIL burst_cnt_saturated got %0d exp 4", dut.u_limiter.cnt); end
      end
      if (i == 4) begin
        checks++; if (dut.u_limiter.cnt !== 4'd0) begin errors++; $display("FAIL burst_cnt_after_cpu got %0d exp 0", dut.u_limiter.cnt); end
      end
      q_m_ack = 1'b1;
      @(posedge clk); #1;
      q_m_ack = 1'b0;
      if (!exp_dma) cpu_m_access = 1'b0;
      #1;
      checks++; if (q_m_access !== 1'b0) begin errors++; $display("FAIL burst_idle_%0d got %b exp 0", i, q_m_access); end
    end
    dma_m_access = 1'b0;
    @(posedge clk); #1;
    checks++; if (dut.u_limiter.cnt !== 4'd0) begin errors++; $display("FAIL burst_cnt_end got %0d exp 0", dut.u_limiter.cnt); end
  endtask

  task automatic test_dma_write;
    dma_m_addr = 19'h00ABC; dma_m_wr_en = 1'b1; dma_m_bytesel = 2'b01;
    dma_m_data_out = 16'h00A5; dma_m_access = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({q_m_access, q_m_wr_en, q_m_bytesel} !== 4'b1101) begin errors++; $display("FAIL dma_write_ctrl_%0d got %b exp 1101", k, {q_m_access, q_m_wr_en, q_m_bytesel}); end
      checks++; if (q_m_data_out !== 16'h00A5) begin errors++; $display("FAIL dma_write_data_%0d got %h exp 00A5", k, q_m_data_out); end
      checks++; if (dma_m_ack !== 1'b0) begin errors++; $display("FAIL dma_write_wait_%0d got %b exp 0", k, dma_m_ack); end
      @(posedge clk); #1;
    end
    q_m_ack = 1'b1;
    #1;
    checks++; if ({dma_m_ack, q_m_wr_en, q_m_data_out} !== {2'b11, 16'h00A5}) begin errors++; $display("FAIL dma_write_ack got %h", {dma_m_ack, q_m_wr_en, q_m_data_out}); end
    @(posedge clk); #1;
    q_m_ack = 1'b0; dma_m_access = 1'b0; dma_m_wr_en = 1'b0;
    #1;
    checks++; if ({q_m_access, q_m_wr_en} !== 2'b00) begin errors++; $display("FAIL dma_write_release got %b exp 00", {q_m_access, q_m_wr_en}); end
  endtask

  task automatic test_reset_mid_grant;
    @(posedge clk); #1;
    dma_m_addr = 19'h7FFFF; dma_m_wr_en = 1'b1; dma_m_bytesel = 2'b10; dma_m_access = 1'b1;
    @(posedge clk); #1;
    checks++; if (dma_active !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_grant got %b exp 1", dma_active); end
    #2;
    reset = 1'b1; q_m_ack = 1'b1;
    #1;
    checks++; if ({q_m_access, dma_active, q_m_wr_en, q_m_bytesel} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctrl got %b exp 00000", {q_m_access, dma_active, q_m_wr_en, q_m_bytesel}); end
    checks++; if (q_m_addr !== 19'h0) begin errors++; $display("FAIL rst_mid_addr got %h exp 0", q_m_addr); end
    checks++; if ({dma_m_ack, cpu_m_ack} !== 2'b00) begin errors++; $display("FAIL rst_mid_acks got %b exp 00", {dma_m_ack, cpu_m_ack}); end
    dma_m_access = 1'b0; dma_m_wr_en = 1'b0; q_m_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_mid_state got %0d exp IDLE", dut.state); end
    cpu_m_addr = 19'h00100; cpu_m_access = 1'b1;
    @(posedge clk); #1;
    checks++; if ({q_m_access, dma_active} !== 2'b10) begin errors++; $display("FAIL rst_mid_post_grant got %b exp 10", {q_m_access, dma_active}); end
    checks++; if (q_m_addr !== 19'h00100) begin errors++; $display("FAIL rst_mid_post_addr got %h exp 00100", q_m_addr); end
    q_m_ack = 1'b1;
    #1;
    checks++; if (cpu_m_ack !== 1'b1) begin errors++; $display("FAIL rst_mid_post_ack got %b exp 1", cpu_m_ack); end
    @(posedge clk); #1;
    q_m_ack = 1'b0; cpu_m_access = 1'b0;
  endtask

  task automatic test_spurious_ack;
    @(posedge clk); #1;
    q_m_ack = 1'b1; q_m_data_in = 16'h1234;
    #1;
    checks++; if ({cpu_m_ack, dma_m_ack, q_m_access} !== 3'b000) begin errors++; $display("FAIL spurious_ack got %b exp 000", {cpu_m_ack, dma_m_ack, q_m_access}); end
    @(posedge clk); #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL spurious_state got %0d exp IDLE", dut.state); end
    checks++; if ({cpu_m_ack, dma_m_ack} !== 2'b00) begin errors++; $display("FAIL spurious_ack_hold got %b exp 00", {cpu_m_ack, dma_m_ack}); end
    q_m_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_burst_limit();
    test_dma_write();
    test_reset_mid_grant();
    test_spurious_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
